// File: rtl/bit_op_arbiter.sv
// bit_op_arbiter: round-robin arbiter that shares one 1-bit XOR unit among NUM_REQ requesters.
// Each accepted request is granted for one cycle and then occupies the unit for OP_LAT cycles.
// The result (operand ^ XOR_MASK) is then returned with the owner's index.
// Optional build macro BIT_OP_ARB_STATS_EN adds the op_count and last_mask_used outputs.
module bit_op_arbiter #(
    parameter int          NUM_REQ  = 4,
    parameter int unsigned XOR_MASK = 1,
    parameter int          OP_LAT   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] operand,
    output logic [NUM_REQ-1:0] grant,
    output logic               result_valid,
    output logic               result,
    output logic [2:0]         result_id,
    output logic               busy
`ifdef BIT_OP_ARB_STATS_EN
    ,
    output logic [15:0]        op_count,
    output logic [0:0]         last_mask_used
`endif
);

    // Only bit 0 of the mask is meaningful; wider overrides are truncated here.
    localparam logic [0:0] MaskBit = 1'(XOR_MASK % 2);
    localparam logic [3:0] CntInit = 4'(OP_LAT - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               rv_q, rv_d;
    logic               result_q, result_d;
    logic [2:0]         result_id_q, result_id_d;
    logic               busy_q, busy_d;
    logic               cap_op_q, cap_op_d;
    logic [2:0]         cap_id_q, cap_id_d;

    // Winner selection: lowest set bit at or above rr_ptr, else lowest set bit overall (wrap).
    logic       hi_found, lo_found;
    logic [2:0] hi_idx, lo_idx;
    logic       hi_op, lo_op;
    logic [2:0] win_idx;
    logic       win_op;

    // Rotating-priority scan split into an upper and a wrapped lower group
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = 3'd0;
        lo_idx   = 3'd0;
        hi_op    = 1'b0;
        lo_op    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = 3'(i);
                lo_op    = operand[i];
            end
            if (req[i] && (i >= int'(rr_ptr_q)) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = 3'(i);
                hi_op    = operand[i];
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
        win_op  = hi_found ? hi_op : lo_op;
    end

    // Next-state logic for the sequencer FSM and its output registers
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = '0;
        rv_d        = 1'b0;
        result_d    = result_q;
        result_id_d = result_id_q;
        cap_op_d    = cap_op_q;
        cap_id_d    = cap_id_q;

        case (state_q)
            StIdle: begin
                if (lo_found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        grant_d[i] = (win_idx == 3'(i));
                    end
                    cap_op_d = win_op;
                    cap_id_d = win_idx;
                    cnt_d    = CntInit;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                rv_d        = 1'b1;
                result_d    = cap_op_q ^ MaskBit;
                result_id_d = cap_id_q;
                rr_ptr_d    = (cap_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : cap_id_q + 3'd1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            rr_ptr_q    <= 3'd0;
            grant_q     <= '0;
            rv_q        <= 1'b0;
            result_q    <= 1'b0;
            result_id_q <= 3'd0;
            busy_q      <= 1'b0;
            cap_op_q    <= 1'b0;
            cap_id_q    <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            rv_q        <= rv_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
            busy_q      <= busy_d;
            cap_op_q    <= cap_op_d;
            cap_id_q    <= cap_id_d;
        end
    end

    assign grant        = grant_q;
    assign result_valid = rv_q;
    assign result       = result_q;
    assign result_id    = result_id_q;
    assign busy         = busy_q;

`ifdef BIT_OP_ARB_STATS_EN
    logic [15:0] op_count_q;
    logic [0:0]  mask_used_q;

    // Completed-operation counter (wraps) and mask report
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q  <= 16'd0;
            mask_used_q <= 1'b0;
        end else begin
            if (rv_d) begin
                op_count_q <= op_count_q + 16'd1;
            end
            mask_used_q <= MaskBit;
        end
    end

    assign op_count       = op_count_q;
    assign last_mask_used = mask_used_q;
`endif

    // Grant is one-hot and never coincides with a result pulse
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_no_overlap: assert property (@(posedge clk) disable iff (rst) !((|grant) && result_valid));

endmodule
